// File: rtl/ripple_mon_pkg.sv
// Shared types and event-record layout for the ripple down-counter monitor.
// Event record is {err, epoch, value}, MSB first.
package ripple_mon_pkg;

  typedef enum logic {
    SEEK  = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_EPOCH_W = 8;

  localparam int EV_VALUE_LSB = 0;

  function automatic int ev_epoch_lsb(input int width);
    return width;
  endfunction

  function automatic int ev_err_pos(input int width, input int epoch_w);
    return width + epoch_w;
  endfunction

  function automatic int ev_width(input int width, input int epoch_w);
    return 1 + width + epoch_w;
  endfunction

endpackage

// File: rtl/ripple_mon_fifo.sv
// Two-entry valid/ready event buffer. The output side is driven purely from
// registered occupancy, so ready never reaches valid combinationally.
module ripple_mon_fifo #(
  parameter int DW = 13
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_drop
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_cnt;

  logic w_pop;
  logic w_push_ok;

  assign o_empty   = (r_cnt == 2'd0);
  assign o_full    = (r_cnt == 2'd2);
  assign o_valid   = !o_empty;
  assign w_pop     = o_valid && i_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = i_push && (!o_full || w_pop);
  assign o_drop    = i_push && !w_push_ok && !i_clr;
  assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_clr) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ripple_count_monitor.sv
// Watches an asynchronous ripple down-counter, filters glitches, counts wraps
// and logs each accepted step (legal or skipped) as an event record.
//
// state | meaning
// SEEK  | no reference value yet; next stable value becomes the reference
// TRACK | reference held; each new stable value is classified and logged
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int EPOCH_W = DEF_EPOCH_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         count,
  input  logic                     clr,
  output logic [WIDTH+EPOCH_W:0]   ev_data,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [EPOCH_W-1:0]       epoch,
  output logic                     skip_err,
  output logic                     ovf
);

  localparam int EV_W      = ev_width(WIDTH, EPOCH_W);
  localparam int EPOCH_LSB = ev_epoch_lsb(WIDTH);
  localparam int ERR_POS   = ev_err_pos(WIDTH, EPOCH_W);
  localparam logic [EPOCH_W-1:0] EPOCH_MAX = {EPOCH_W{1'b1}};

  mon_state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_s1, r_s2, r_s2_prev, r_stable, r_prev;
  logic [2:0]         r_hist_vld;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_skip_err, r_ovf;

  logic               w_stable_vld, w_new_stable;
  logic [WIDTH-1:0]   w_prev_dec;
  logic               w_push, w_err, w_wrap, w_prev_ld, w_drop;
  logic [EPOCH_W-1:0] w_epoch_nxt;
  logic [EV_W-1:0]    w_ev;
  logic               w_fifo_full, w_fifo_empty;

  // History-valid bits keep reset/clear zeros from posing as a settled value.
  assign w_stable_vld = r_hist_vld[2] && (r_s2 == r_s2_prev);
  assign w_new_stable = w_stable_vld && (r_s2 != r_stable);
  assign w_prev_dec   = r_prev - WIDTH'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_err       = 1'b0;
    w_wrap      = 1'b0;
    w_prev_ld   = 1'b0;
    case (r_state)
      SEEK: begin
        if (w_stable_vld) begin
          w_prev_ld   = 1'b1;
          w_state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (w_new_stable) begin
          w_prev_ld = 1'b1;
          w_push    = 1'b1;
          if (r_s2 == w_prev_dec) w_wrap = (r_prev == '0);
          else                    w_err  = 1'b1;
        end
      end
      default: w_state_nxt = SEEK;
    endcase
  end

  assign w_epoch_nxt = (w_wrap && (r_epoch != EPOCH_MAX)) ? r_epoch + EPOCH_W'(1) : r_epoch;

  always_comb begin
    w_ev = '0;
    w_ev[ERR_POS]                   = w_err;
    w_ev[EPOCH_LSB +: EPOCH_W]      = w_epoch_nxt;
    w_ev[EV_VALUE_LSB +: WIDTH]     = r_s2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= SEEK;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s2_prev  <= '0;
      r_hist_vld <= '0;
      r_stable   <= '0;
      r_prev     <= '0;
      r_epoch    <= '0;
      r_skip_err <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (clr) begin
      r_state    <= SEEK;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s2_prev  <= '0;
      r_hist_vld <= '0;
      r_stable   <= '0;
      r_prev     <= '0;
      r_epoch    <= '0;
      r_skip_err <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s1       <= count;
      r_s2       <= r_s1;
      r_s2_prev  <= r_s2;
      r_hist_vld <= {r_hist_vld[1:0], 1'b1};
      if (w_stable_vld) r_stable <= r_s2;
      if (w_prev_ld)    r_prev   <= r_s2;
      r_epoch    <= w_epoch_nxt;
      if (w_err)  r_skip_err <= 1'b1;
      if (w_drop) r_ovf      <= 1'b1;
    end
  end

  ripple_mon_fifo #(.DW(EV_W)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_data  (w_ev),
    .i_ready (ev_ready),
    .o_valid (ev_valid),
    .o_data  (ev_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_drop  (w_drop)
  );

  assign epoch    = r_epoch;
  assign skip_err = r_skip_err;
  assign ovf      = r_ovf;

endmodule

// File: doc/ripple_count_monitor.md
RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001 Parameter WIDTH, default 4: width of the monitored down-count.
REQ-002 Parameter EPOCH_W, default 8: width of the wrap (epoch) counter.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port count  input  WIDTH  ripple down-counter value; asynchronous to clk and may glitch.
REQ-006 Port clr  input  1  synchronous clear of epoch, flags and buffer; returns the block to SEEK.
REQ-007 Port ev_data  output  1+EPOCH_W+WIDTH  event record {err, epoch, value}, MSB first.
REQ-008 Port ev_valid  output  1  ev_data holds a buffered event.
REQ-009 Port ev_ready  input  1  the consumer accepts ev_data when ev_valid and ev_ready are both high at a clk edge.
REQ-010 Port epoch  output  EPOCH_W  current wrap count.
REQ-011 Port skip_err  output  1  sticky flag: an illegal step was detected.
REQ-012 Port ovf  output  1  sticky flag: an event was dropped because the buffer was full.

Function
REQ-013 count SHALL pass through a two-flop synchronizer (s1, s2).
REQ-014 Stability filter: a value becomes "stable" only when s2 equals its previous-cycle value; stable register updates at that edge.
REQ-015 A value that settles before edge E0 SHALL produce ev_valid high immediately after edge E0+3 if the buffer was empty.
REQ-016 FSM states: SEEK (no reference value) and TRACK.
REQ-017 SEEK: on the first stable value, load prev := value, push no event, and go to TRACK.
REQ-018 TRACK, stable == prev: no action.
REQ-019 TRACK, stable == (prev-1) mod 2^WIDTH: legal step; push {0, epoch, value}; prev := value.
REQ-020 Wrap: on a legal step from prev == 0 to 2^WIDTH-1, epoch SHALL increment before the push, saturating at 2^EPOCH_W-1; the pushed record carries the new epoch.
REQ-021 TRACK, any other new stable value: set skip_err, push {1, epoch, value}, prev := value, and remain in TRACK; epoch is unchanged.
REQ-022 Buffer: 2-entry FIFO; ev_data/ev_valid driven from the head; no combinational path from ev_ready to ev_valid.
REQ-023 Push when full and no pop in the same cycle: drop the new event and set ovf; buffer contents are unchanged.
REQ-024 Push and pop in the same cycle when full: both SHALL take effect, and no ovf is set.
REQ-025 ev_data SHALL hold stable while ev_valid is high and ev_ready is low.
REQ-026 clr has priority over a simultaneous push/pop: empties the FIFO, zeros epoch, skip_err and ovf, enters SEEK, and clears the synchronizer history.

Reset
REQ-027 rst low SHALL asynchronously force: SEEK, s1=s2=stable=prev=0, epoch=0, skip_err=0, ovf=0, FIFO empty, ev_valid=0, ev_data=0.
REQ-028 Reset release SHALL take effect synchronously; the first stable value after release is handled as in SEEK, with no event.
REQ-029 Reset asserted mid-operation SHALL discard buffered events without delivering them.

Structure
REQ-030 Shared package ripple_mon_pkg: FSM state enum (SEEK, TRACK), default WIDTH/EPOCH_W, and event field offsets.
REQ-031 One sub-module, ripple_mon_fifo (2-entry, valid/ready, full/empty, parameterised data width); all other logic stays in ripple_count_monitor.
REQ-032 Target size: 120-400 lines of RTL in total.

Verification
REQ-033 Reset, then count held at 5 for 10 cycles -> SEEK to TRACK, ev_valid stays 0, epoch=0.
REQ-034 Sequence 3,2,1,0,15,14, each held 6 cycles, ev_ready=1 -> events {0,0,2},{0,0,1},{0,0,0},{0,1,15},{0,1,14}; epoch=1.
REQ-035 Single-cycle glitch 9 inside a steady 4 -> no event, skip_err=0; then jump 4 to 1 -> event {1,e,1}, skip_err=1.
REQ-036 ev_ready=0 while three legal steps occur -> first two events held, ovf=1 on the third; raising ev_ready delivers exactly two events, in order.
REQ-037 Wrap driven 260 times -> epoch saturates at 255.
REQ-038 rst pulsed low mid-stream with two events buffered -> ev_valid=0 immediately, epoch=0; stream restarts in SEEK.
